capture_buffer_ctrl: RTL and testbench



---
 rtl/capture_buffer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_capture_buffer_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer_ctrl.sv
// Capture buffer: stores a programmable run of consecutive dclk words into RAM for host readback.
// Optional level trigger gating the start of storage is compiled in with `define CAPTURE_BUFFER_TRIG_EN.
module capture_buffer_ctrl #(
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  dclk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DEPTH_LOG2:0]   cap_len,
`ifdef CAPTURE_BUFFER_TRIG_EN
    input  logic                  trig_en,
    input  logic [7:0]            trig_level,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   wr_count,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam int                CNT_W     = DEPTH_LOG2 + 1;
    localparam int                NBYTES    = DATA_W / 8;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        wr_count_q, wr_count_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_waddr;

    logic [CNT_W-1:0]        len_clamped;
    logic                    trig_hit;
    logic                    start_wait;

    // Zero or anything beyond the RAM depth means a full-depth capture, so the pointer never wraps.
    always_comb begin
        if ((cap_len == '0) || (cap_len > DEPTH_CNT)) begin
            len_clamped = DEPTH_CNT;
        end else begin
            len_clamped = cap_len;
        end
    end

`ifdef CAPTURE_BUFFER_TRIG_EN
    always_comb begin
        trig_hit = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_data[i*8 +: 8] >= trig_level) begin
                trig_hit = 1'b1;
            end
        end
    end

    assign start_wait = trig_en;
`else
    assign trig_hit   = 1'b0;
    assign start_wait = 1'b0;
`endif

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_count_q <= '0;
            ptr_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_count_q <= wr_count_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_count_d = wr_count_q;
        ptr_d      = ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        len_d      = len_clamped;
                        wr_count_d = '0;
                        ptr_d      = '0;
                        state_d    = start_wait ? WAIT_TRIG : FILL;
                    end
                end
                // The triggering word itself is the first word stored.
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        mem_we     = 1'b1;
                        mem_waddr  = '0;
                        ptr_d      = DEPTH_LOG2'(1);
                        wr_count_d = CNT_W'(1);
                        state_d    = (len_q == CNT_W'(1)) ? DONE : FILL;
                    end
                end
                FILL: begin
                    mem_we     = 1'b1;
                    mem_waddr  = ptr_q;
                    ptr_d      = ptr_q + DEPTH_LOG2'(1);
                    wr_count_d = wr_count_q + CNT_W'(1);
                    if ((wr_count_q + CNT_W'(1)) == len_q) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == WAIT_TRIG) || (state_q == FILL);
        done     = (state_q == DONE);
        wr_count = wr_count_q;
        rd_data  = rd_data_q;
    end

    // Read-first: the RAM is sampled before this edge's write lands.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge dclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_data;
        end
    end

    busy_done_exclusive: assert property (@(posedge dclk) disable iff (!rst_n) !(busy && done));
    count_in_range:      assert property (@(posedge dclk) disable iff (!rst_n) wr_count_q <= DEPTH_CNT);

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Self-checking bench for capture_buffer_ctrl: random capture data checked against a word-indexed model RAM.
module tb_capture_buffer_ctrl;

    localparam int DATA_W     = 64;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                  dclk = 1'b0;
    logic                  rst_n;
    logic [DATA_W-1:0]     wr_data;
    logic                  arm;
    logic                  abort;
    logic [DEPTH_LOG2:0]   cap_len;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2:0]   wr_count;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0]     rd_data;
`ifdef CAPTURE_BUFFER_TRIG_EN
    logic                  trig_en;
    logic [7:0]            trig_level;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];

    capture_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .arm       (arm),
        .abort     (abort),
        .cap_len   (cap_len),
`ifdef CAPTURE_BUFFER_TRIG_EN
        .trig_en   (trig_en),
        .trig_level(trig_level),
`endif
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 dclk = ~dclk;

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] randWord();
        return {$urandom, $urandom};
    endfunction

    function automatic int effLen(input int cmd);
        return ((cmd == 0) || (cmd > DEPTH)) ? DEPTH : cmd;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkStatus(input string tag, input logic exp_busy, input logic exp_done, input int exp_count);
        checkOutput({tag, ".busy"}, 64'(busy), 64'(exp_busy));
        checkOutput({tag, ".done"}, 64'(done), 64'(exp_done));
        checkOutput({tag, ".wr_count"}, 64'(wr_count), 64'(exp_count));
    endtask

    task automatic readCheck(input int addr, input string tag);
        rd_addr = DEPTH_LOG2'(addr);
        rd_en   = 1'b1;
        step();
        rd_en   = 1'b0;
        checkOutput($sformatf("%s.rd%0d", tag, addr), rd_data, model_mem[addr]);
    endtask

    // Arms one capture and feeds its words; word i after the arm edge must land at address i.
    task automatic applyStimulus(input int len_cmd, input bit use_counter, input logic [63:0] k, input string tag);
        int n;
        logic [DATA_W-1:0] w;
        n       = effLen(len_cmd);
        cap_len = (DEPTH_LOG2+1)'(len_cmd);
        arm     = 1'b1;
        wr_data = randWord();
        step();
        arm     = 1'b0;
        cap_len = (DEPTH_LOG2+1)'($urandom);
        for (int i = 0; i < n; i++) begin
            w            = use_counter ? (k + 64'(i)) : randWord();
            wr_data      = w;
            model_mem[i] = w;
            step();
            if (i < n - 1) begin
                checkStatus($sformatf("%s.fill%0d", tag, i), 1'b1, 1'b0, i + 1);
            end
        end
        checkStatus({tag, ".end"}, 1'b0, 1'b1, n);
    endtask

    initial begin
        logic [63:0]       k;
        logic [63:0]       old0;
        logic [63:0]       held;
        logic [DATA_W-1:0] w;
        int                n;

        rst_n   = 1'b0;
        wr_data = '0;
        arm     = 1'b0;
        abort   = 1'b0;
        cap_len = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
`ifdef CAPTURE_BUFFER_TRIG_EN
        trig_en    = 1'b0;
        trig_level = 8'h00;
`endif
        #3;
        checkStatus("reset", 1'b0, 1'b0, 0);
        checkOutput("reset.rd_data", rd_data, 64'h0);
        step();
        #2 rst_n = 1'b1;
        step();
        checkStatus("idle", 1'b0, 1'b0, 0);
        $display("[TB] reset done");

        k = randWord();
        applyStimulus(16, 1'b1, k, "basic");
        for (int a = 0; a < 16; a++) readCheck(a, "basic");
        held    = rd_data;
        rd_addr = 10'd3;
        step();
        checkOutput("rd_hold", rd_data, held);
        step();
        checkStatus("done_hold", 1'b0, 1'b1, 16);

        applyStimulus(1, 1'b0, 64'h0, "len1");
        readCheck(0, "len1");

        applyStimulus(0, 1'b0, 64'h0, "clamp0");
        readCheck(1023, "clamp0");
        readCheck(0, "clamp0");
        applyStimulus(2000, 1'b0, 64'h0, "clamp2000");
        readCheck(1023, "clamp2000");
        readCheck(0, "clamp2000");
        for (int j = 0; j < 4; j++) readCheck($urandom_range(0, DEPTH - 1), "clamp2000");
        $display("[TB] clamp captures done");

        cap_len = 11'd10;
        arm     = 1'b1;
        wr_data = randWord();
        step();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w            = randWord();
            wr_data      = w;
            model_mem[i] = w;
            step();
        end
        abort   = 1'b1;
        arm     = 1'b1;
        wr_data = randWord();
        step();
        abort = 1'b0;
        arm   = 1'b0;
        checkStatus("abort", 1'b0, 1'b0, 5);
        step();
        checkStatus("abort_idle", 1'b0, 1'b0, 5);
        old0    = model_mem[0];
        cap_len = 11'd3;
        arm     = 1'b1;
        wr_data = randWord();
        step();
        arm = 1'b0;
        checkStatus("rearm", 1'b1, 1'b0, 0);
        w       = randWord();
        wr_data = w;
        rd_addr = 10'd0;
        rd_en   = 1'b1;
        step();
        rd_en = 1'b0;
        checkOutput("read_first", rd_data, old0);
        model_mem[0] = w;
        for (int i = 1; i < 3; i++) begin
            w            = randWord();
            wr_data      = w;
            model_mem[i] = w;
            step();
        end
        checkStatus("rearm.end", 1'b0, 1'b1, 3);
        for (int a = 0; a < 4; a++) readCheck(a, "rearm");

        cap_len = 11'd8;
        arm     = 1'b1;
        wr_data = randWord();
        step();
        arm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w            = randWord();
            wr_data      = w;
            model_mem[i] = w;
            arm          = (i == 2) || (i == 5);
            cap_len      = arm ? 11'd2 : 11'd8;
            step();
            arm = 1'b0;
            checkStatus($sformatf("busyarm%0d", i), (i != 7), (i == 7), i + 1);
        end
        for (int a = 0; a < 8; a++) readCheck(a, "busyarm");

        for (int r = 0; r < 6; r++) begin
            n = (r % 2 == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(0, 2047));
            applyStimulus(n, 1'b0, 64'h0, $sformatf("rand%0d", r));
            for (int j = 0; j < 3; j++) readCheck($urandom_range(0, effLen(n) - 1), $sformatf("rand%0d", r));
        end
        $display("[TB] random captures done");

        readCheck(0, "prereset");
        cap_len = 11'd20;
        arm     = 1'b1;
        wr_data = randWord();
        step();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w            = randWord();
            wr_data      = w;
            model_mem[i] = w;
            step();
        end
        checkStatus("midfill", 1'b1, 1'b0, 6);
        #2 rst_n = 1'b0;
        #1;
        checkStatus("async_reset", 1'b0, 1'b0, 0);
        checkOutput("async_reset.rd_data", rd_data, 64'h0);
        step();
        #2 rst_n = 1'b1;
        step();
        checkStatus("post_reset", 1'b0, 1'b0, 0);

`ifdef CAPTURE_BUFFER_TRIG_EN
        trig_en    = 1'b1;
        trig_level = 8'h80;
        cap_len    = 11'd4;
        arm        = 1'b1;
        wr_data    = {8{8'h10}};
        step();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_data = {8{8'h10}};
            step();
            checkStatus($sformatf("trigwait%0d", i), 1'b1, 1'b0, 0);
        end
        w            = {8{8'h10}};
        w[47:40]     = 8'h80;
        wr_data      = w;
        model_mem[0] = w;
        step();
        checkStatus("trighit", 1'b1, 1'b0, 1);
        for (int i = 1; i < 4; i++) begin
            w            = randWord();
            wr_data      = w;
            model_mem[i] = w;
            step();
            checkStatus($sformatf("trigfill%0d", i), (i != 3), (i == 3), i + 1);
        end
        for (int a = 0; a < 4; a++) readCheck(a, "trig");
        trig_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
